// File: rtl/adder_pkg.sv
// Shared definitions for the serial carry-lookahead adder.
//   state_t        : FSM states of the sequencer
//   NIB            : bits handled per step by the CLA slice
//   calc_steps()   : number of nibble steps for a given operand width
//   calc_cnt_w()   : width of the step counter for a given operand width
package adder_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width);
    return width / NIB;
  endfunction

  // Counter only has to reach N-1, so clog2(N) bits; never narrower than 1.
  function automatic int calc_cnt_w(input int width);
    int n;
    n = width / NIB;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/CLA.sv
// 4-bit carry-lookahead adder slice.
//   a, b     : nibble operands
//   carryIn  : carry into bit 0
//   sum      : nibble sum
//   carryOut : carry out of bit 3
// All carries are flattened generate/propagate terms of carryIn so no carry
// ripples through another carry bit.
module CLA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carryIn,
  output logic [3:0] sum,
  output logic       carryOut
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c1 = w_g[0] | (w_p[0] & carryIn);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & carryIn);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & carryIn);
  assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & carryIn);

  assign sum      = w_p ^ {w_c3, w_c2, w_c1, carryIn};
  assign carryOut = w_c4;

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble
// per cycle, least-significant nibble first.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready : result handshake
//   sum, cout             : registered result, held until the next completion
//   busy                  : high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble per cycle through the CLA, N cycles
// DONE  | result presented, waiting for out_ready
module serial_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            N    = calc_steps(WIDTH);
  localparam int            CW   = calc_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  // Only the upper WIDTH-NIB bits need storing: the final nibble is taken
  // straight from the CLA on the completing edge.
  logic [WIDTH-NIB-1:0] r_sum_sh;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;
  logic                 r_carry;
  logic [CW-1:0]        r_cnt;

  logic [NIB-1:0]       w_cla_sum;
  logic                 w_cla_cout;
  logic                 w_last;
  logic [WIDTH-1:0]     w_sum_nxt;

  CLA u_cla (
    .a        (r_a[NIB-1:0]),
    .b        (r_b[NIB-1:0]),
    .carryIn  (r_carry),
    .sum      (w_cla_sum),
    .carryOut (w_cla_cout)
  );

  assign w_last    = (r_cnt == LAST);
  assign w_sum_nxt = {w_cla_sum, r_sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a      <= r_a >> NIB;
          r_b      <= r_b >> NIB;
          r_sum_sh <= w_sum_nxt[WIDTH-1:NIB];
          r_carry  <= w_cla_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_sum_nxt;
            r_cout <= w_cla_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_cla_adder.sv
module tb_serial_cla_adder;

  localparam int WAIT_MAX = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst_n;

  logic        iv32, ir32, ov32, or32, cin32, cout32, busy32;
  logic [31:0] a32, b32, sum32;
  logic        iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;

  logic [32:0] q32[$];
  logic [8:0]  q8[$];

  int n_tests = 0;
  int n_fail  = 0;

  serial_cla_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
    .sum(sum32), .cout(cout32), .busy(busy32)
  );

  serial_cla_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  // Drive one 32-bit operation and wait for out_valid; returns observations.
  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output int lat, output logic [32:0] got, output logic ok);
    int guard = 0;
    int t0;
    while (ir32 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    ok = (ir32 === 1'b1);
    a32 = a; b32 = b; cin32 = c; iv32 = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    iv32 = 1'b0;
    q32.push_back({1'b0, a} + {1'b0, b} + 33'(c));
    guard = 0;
    while (ov32 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    ok  = ok && (ov32 === 1'b1);
    lat = cyc - t0;
    got = {cout32, sum32};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv32 = 0; or32 = 0; a32 = '0; b32 = '0; cin32 = 0;
    iv8  = 0; or8  = 0; a8  = '0; b8  = '0; cin8  = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ov32, busy32, cout32, sum32} !== 35'd0)
      begin n_fail++; $display("FAIL reset32_outs: got %h want 0", {ov32, busy32, cout32, sum32}); end
    n_tests++;
    if ({ov8, busy8, cout8, sum8} !== 11'd0)
      begin n_fail++; $display("FAIL reset8_outs: got %h want 0", {ov8, busy8, cout8, sum8}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ir32, ir8} !== 2'b11)
      begin n_fail++; $display("FAIL reset_in_ready: got %b want 11", {ir32, ir8}); end
  endtask

  task automatic test_basic();
    int lat; logic [32:0] got, exp; logic ok;
    or32 = 1'b1;
    run_op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, got, ok);
    exp = q32.pop_front();
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic1_timeout: out_valid not seen"); end
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic1_latency: got %0d want 8", lat); end
    n_tests++;
    if (got !== exp || exp !== 33'h1_0000_0000)
      begin n_fail++; $display("FAIL basic1_result: got %h want %h", got, exp); end
    @(posedge clk); #1;
    n_tests++;
    if ({ov32, ir32} !== 2'b01)
      begin n_fail++; $display("FAIL basic1_handshake: got ov/ir %b want 01", {ov32, ir32}); end
    run_op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat, got, ok);
    exp = q32.pop_front();
    n_tests++;
    if (!ok || got !== exp || exp !== 33'h0_ACF1_3569)
      begin n_fail++; $display("FAIL basic2_result: got %h want %h ok %b", got, exp, ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [32:0] got, exp; logic ok;
    or32 = 1'b0;
    run_op32(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, lat, got, ok);
    n_tests++;
    if (!ok || lat !== 8)
      begin n_fail++; $display("FAIL bp_latency: got %0d want 8 ok %b", lat, ok); end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin a32 = 32'h5555_5555; b32 = 32'hAAAA_AAAA; cin32 = 1'b1; iv32 = 1'b1; end
      if (k == 2) iv32 = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({ov32, ir32, cout32, sum32} !== {2'b10, got})
        begin n_fail++; $display("FAIL bp_hold%0d: got %h want %h", k, {ov32, ir32, cout32, sum32}, {2'b10, got}); end
    end
    exp = q32.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_result: got %h want %h", got, exp); end
    or32 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ov32, ir32, busy32} !== 3'b010)
      begin n_fail++; $display("FAIL bp_release: got %b want 010", {ov32, ir32, busy32}); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy32 !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_op: busy got %b want 0", busy32); end
  endtask

  task automatic test_run_ignore();
    int guard, t0; logic [32:0] exp;
    or32 = 1'b1;
    a32 = 32'h0F0F_0F0F; b32 = 32'h1111_1111; cin32 = 1'b0; iv32 = 1'b1;
    q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
    @(posedge clk); #1;
    t0 = cyc;
    a32 = 32'h8000_0000; b32 = 32'h8000_0001; cin32 = 1'b1;
    q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
    guard = 0;
    while (ov32 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    exp = q32.pop_front();
    n_tests++;
    if (ov32 !== 1'b1 || cyc - t0 !== 8 || {cout32, sum32} !== exp)
      begin n_fail++; $display("FAIL ign_first: got %h lat %0d want %h lat 8", {cout32, sum32}, cyc - t0, exp); end
    @(posedge clk); #1;
    n_tests++;
    if ({ov32, ir32, busy32} !== 3'b010)
      begin n_fail++; $display("FAIL ign_handshake: got %b want 010", {ov32, ir32, busy32}); end
    @(posedge clk); #1;
    t0 = cyc;
    iv32 = 1'b0;
    n_tests++;
    if ({ir32, busy32} !== 2'b01)
      begin n_fail++; $display("FAIL ign_next_accept: got %b want 01", {ir32, busy32}); end
    guard = 0;
    while (ov32 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    exp = q32.pop_front();
    n_tests++;
    if (ov32 !== 1'b1 || cyc - t0 !== 8 || {cout32, sum32} !== exp)
      begin n_fail++; $display("FAIL ign_second: got %h lat %0d want %h lat 8", {cout32, sum32}, cyc - t0, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [32:0] got, exp; logic ok; logic seen;
    or32 = 1'b1;
    a32 = 32'h7777_7777; b32 = 32'h3333_3333; cin32 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov32, busy32, cout32, sum32} !== 35'd0)
      begin n_fail++; $display("FAIL midrst_clear: got %h want 0", {ov32, busy32, cout32, sum32}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov32 === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result: out_valid seen %b want 0", seen); end
    run_op32(32'h0000_0010, 32'h0000_0020, 1'b0, lat, got, ok);
    exp = q32.pop_front();
    n_tests++;
    if (!ok || got !== exp || exp !== 33'h30)
      begin n_fail++; $display("FAIL midrst_next: got %h want %h ok %b", got, exp, ok); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back32();
    int guard, prev, t, n_out; logic [32:0] exp;
    logic [31:0] ra, rb; logic rc;
    or32 = 1'b1; n_out = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      ra = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      rc = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a32 = ra; b32 = rb; cin32 = rc; iv32 = 1'b1;
      q32.push_back({1'b0, ra} + {1'b0, rb} + 33'(rc));
      guard = 0;
      while (ir32 !== 1'b1 && guard < WAIT_MAX) begin
        @(posedge clk); #1; guard++;
        if (ov32 === 1'b1) begin
          exp = q32.pop_front(); n_out++;
          n_tests++;
          if ({cout32, sum32} !== exp)
            begin n_fail++; $display("FAIL b2b32_result: got %h want %h", {cout32, sum32}, exp); end
        end
      end
      if (ir32 !== 1'b1) begin
        n_tests++; n_fail++; $display("FAIL b2b32_timeout: in_ready %b want 1", ir32); break;
      end
      @(posedge clk); #1;
      t = cyc;
      if (i > 0) begin
        n_tests++;
        if (t - prev !== 10) begin n_fail++; $display("FAIL b2b32_spacing: got %0d want 10", t - prev); end
      end
      prev = t;
    end
    iv32 = 1'b0;
    guard = 0;
    while (ov32 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    if (ov32 === 1'b1) begin exp = q32.pop_front(); n_out++; end else exp = 'x;
    n_tests++;
    if ({cout32, sum32} !== exp || n_out !== 200)
      begin n_fail++; $display("FAIL b2b32_last: got %h want %h outputs %0d want 200", {cout32, sum32}, exp, n_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back8();
    int guard, prev, t, n_out; logic [8:0] exp;
    logic [7:0] ra, rb; logic rc;
    or8 = 1'b1; n_out = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      ra = (i == 0) ? 8'hFF : 8'($urandom);
      rb = (i == 0) ? 8'h00 : 8'($urandom);
      rc = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a8 = ra; b8 = rb; cin8 = rc; iv8 = 1'b1;
      q8.push_back({1'b0, ra} + {1'b0, rb} + 9'(rc));
      guard = 0;
      while (ir8 !== 1'b1 && guard < WAIT_MAX) begin
        @(posedge clk); #1; guard++;
        if (ov8 === 1'b1) begin
          exp = q8.pop_front(); n_out++;
          n_tests++;
          if ({cout8, sum8} !== exp)
            begin n_fail++; $display("FAIL b2b8_result: got %h want %h", {cout8, sum8}, exp); end
        end
      end
      if (ir8 !== 1'b1) begin
        n_tests++; n_fail++; $display("FAIL b2b8_timeout: in_ready %b want 1", ir8); break;
      end
      @(posedge clk); #1;
      t = cyc;
      if (i > 0) begin
        n_tests++;
        if (t - prev !== 4) begin n_fail++; $display("FAIL b2b8_spacing: got %0d want 4", t - prev); end
      end
      prev = t;
    end
    iv8 = 1'b0;
    guard = 0;
    while (ov8 !== 1'b1 && guard < WAIT_MAX) begin @(posedge clk); #1; guard++; end
    if (ov8 === 1'b1) begin exp = q8.pop_front(); n_out++; end else exp = 'x;
    n_tests++;
    if ({cout8, sum8} !== exp || n_out !== 200)
      begin n_fail++; $display("FAIL b2b8_last: got %h want %h outputs %0d want 200", {cout8, sum8}, exp, n_out); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_run_ignore();
    test_reset_mid_run();
    test_back_to_back32();
    test_back_to_back8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_cla_adder.md
# serial_cla_adder

Multi-cycle WIDTH-bit adder that reuses a single 4-bit carry-lookahead adder (`CLA`) over WIDTH/4 cycles, one nibble per cycle, least-significant first. Sits directly upstream of the `CLA` stage: it sequences operand nibbles and the carry into `CLA` and captures its sum/carry outputs. Operands enter and results leave through valid/ready handshakes. Used where area matters more than single-cycle throughput.

## Interface
- `WIDTH`, default 32: operand/result width; must be a multiple of 4 and ≥ 8.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A, sampled only on accept.
- `b`  in  WIDTH  operand B, sampled only on accept.
- `cin`  in  1  carry-in, sampled only on accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  WIDTH  registered result, a+b+cin mod 2^WIDTH.
- `cout`  out  1  registered carry-out of bit WIDTH-1.
- `busy`  out  1  high in RUN or DONE.

## Operation
- N = WIDTH/4 nibble steps. FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. Accept on `in_valid && in_ready`: load A/B shift registers with `a`/`b`, carry register with `cin`, clear step counter, go to RUN.
- RUN: `CLA` gets A[3:0], B[3:0], carry register. Each cycle:
  - shift A/B right by 4;
  - shift the `CLA` sum nibble into the top of the sum shift register;
  - load the carry register from `CLA` carryOut;
  - increment the counter.
  - After step N-1 completes: `sum` = full result, `cout` = final carry, go to DONE.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- `in_ready` = (state==IDLE) only. `in_valid` in RUN/DONE is ignored; operands are not queued. Input changes after accept have no effect.
- `sum`/`cout` hold the last result after handshake until the next completion. They are meaningful only while `out_valid`=1.
- Step counter width is clog2(N). No wrap is observable, because RUN exits at count N-1.
- Reset (any state, including mid-RUN): state IDLE; `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, shift/carry/counter registers 0. `in_ready`=1 once `rst_n` is high. A partial result is discarded and never presented.

## Timing
- Accept at edge T. Nibble k is written at edge T+1+k. `out_valid` rises after edge T+N: latency N cycles (8 for WIDTH=32).
- `busy` rises after edge T and falls after the output-handshake edge.
- Output handshake at edge U: `out_valid`=0 and `in_ready`=1 after U. The earliest next accept is edge U+1.
- With `out_ready` tied high, consecutive accepts are N+2 cycles apart.
- `out_valid`, `sum` and `cout` are stable while `out_valid`=1 and `out_ready`=0.
- Critical path: one `CLA` plus shift-register mux. No combinational path from inputs to outputs. `in_ready` is decoded from state only.

## Structure
- Shared package `adder_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - the nibble width constant NIB=4;
  - a function computing N and counter width from WIDTH.
- One sub-module: the existing 4-bit `CLA`, instantiated once. Its carryIn is driven by the carry register and its carryOut feeds it.
- Remaining logic stays in this module: FSM, counter, three shift registers, carry register.

## Test plan
- `a`=0xFFFFFFFF, `b`=0x00000001, `cin`=0, WIDTH=32 -> `sum`=0x00000000, `cout`=1, `out_valid` exactly 8 cycles after accept.
- `a`=0x12345678, `b`=0x9ABCDEF0, `cin`=1 -> `sum`=0xACF13569, `cout`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> `out_valid`, `sum`, `cout` constant. `in_ready`=0 throughout, and an `in_valid` pulse with new operands is ignored.
- Operands changed and `in_valid` re-asserted during RUN -> result equals the first operation only. The next accept happens only after the output handshake.
- Drop `rst_n` 3 cycles into RUN -> `out_valid`=0, `sum`=0, `busy`=0 immediately. No result is presented. A following operation 0x00000010+0x00000020 yields 0x00000030.
- `out_ready` tied 1: 200 random back-to-back operations at WIDTH=32 and WIDTH=8 -> all match the a+b+cin reference model, with accepts exactly N+2 cycles apart.
